// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-channel registered arbitrating multiplexer with valid/ready handshake
//
// Funnels N producer channels into one registered output port. Arbitration is
// round-robin (prio_mode=0) or fixed lowest-index priority (prio_mode=1),
// selectable every cycle. One output register stage: 1-cycle latency, full
// throughput.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data  [N*WIDTH]    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid [N]          channel i offers a word
//   in_ready [N]          channel i word taken this cycle (at most one bit high)
//   prio_mode             0 = round-robin, 1 = fixed priority
//   out_data [WIDTH]      registered selected word
//   out_sel  [SELW]       channel that supplied out_data
//   out_valid, out_ready  output handshake
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 prio_mode,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] gidx;
    logic [SELW-1:0] ptr_next;
    logic [N-1:0]    grant;
    logic            load_en;
    logic            accept;

    // Scan from the far end of the search order back towards its start, so
    // the last hit written is the first candidate in search order. The
    // round-robin index is reduced modulo N, so values >= N never appear even
    // when N is not a power of two.
    always_comb begin
        int idx;
        gidx = '0;
        idx  = 0;
        for (int off = N - 1; off >= 0; off--) begin
            if (prio_mode) begin
                idx = off;
            end else begin
                idx = (int'(rr_ptr) + off) % N;
            end
            if (in_valid[idx]) begin
                gidx = idx[SELW-1:0];
            end
        end
        grant = (|in_valid) ? (N'(1) << gidx) : '0;
    end

    // The register may load when empty or when being drained this same cycle.
    assign load_en  = !out_valid || out_ready;
    assign in_ready = rst ? '0 : (grant & {N{load_en}});
    assign accept   = |in_ready;
    assign ptr_next = (gidx == SELW'(N - 1)) ? '0 : gidx + SELW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                out_data  <= in_data[gidx*WIDTH +: WIDTH];
                out_sel   <= gidx;
                out_valid <= 1'b1;
                rr_ptr    <= ptr_next;
            end else if (out_ready) begin
                // Drain with nothing to replace it: data and index hold.
                out_valid <= 1'b0;
            end
        end
    end

endmodule
